// File: rtl/shiftreg_sched.sv
// -----------------------------------------------------------------------------
// shiftreg_sched
//   Round-robin scheduler that lets two 4-bit requesters share one external
//   PISO shift register. A granted word is loaded into the PISO for one cycle
//   and then shifted for four cycles, MSB first. The serial stream comes back
//   on piso_dout and is forwarded on ser_bit, tagged with valid/source/last
//   flags that are aligned to the PISO's one-cycle output register.
//
// Ports
//   clk                      sole clock, rising edge
//   rst                      asynchronous, active-low reset
//   req0_valid / req1_valid  requester n has a word pending
//   req0_data  / req1_data   requester n word (held while valid and not ready)
//   req0_ready / req1_ready  word accepted this cycle
//   flush                    synchronous abort of the in-flight word
//   piso_load / piso_din     PISO parallel load strobe and data
//   piso_rst                 PISO synchronous active-high reset
//   piso_dout                PISO serial output
//   ser_bit                  combinational copy of piso_dout
//   ser_valid                ser_bit is a live data bit
//   ser_src                  requester index owning ser_bit
//   ser_last                 ser_bit is bit 0 of its word
//   busy                     scheduler is not idle
//   err                      error sink, tied low here (filled in by TMR)
// -----------------------------------------------------------------------------
(* tamara_triplicate *)
module shiftreg_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  input  logic       flush,
  output logic       piso_load,
  output logic [3:0] piso_din,
  output logic       piso_rst,
  input  logic       piso_dout,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       ser_src,
  output logic       ser_last,
  output logic       busy,
  (* tamara_error_sink *)
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       g_q, g_d;
  logic       lw_q, lw_d;
  logic       ser_valid_q, ser_valid_d;
  logic       ser_last_q, ser_last_d;
  logic       ser_src_q, ser_src_d;
  logic       piso_rst_q, piso_rst_d;

  logic       any_vld;
  logic       winner;
  logic       arb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      g_q         <= 1'b0;
      lw_q        <= 1'b1;   // requester 0 wins the first tie
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      ser_src_q   <= 1'b0;
      piso_rst_q  <= 1'b1;   // keep the PISO cleared until the first edge after release
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      g_q         <= g_d;
      lw_q        <= lw_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      ser_src_q   <= ser_src_d;
      piso_rst_q  <= piso_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    g_d         = g_q;
    lw_d        = lw_q;
    piso_load   = 1'b0;
    piso_din    = 4'd0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    any_vld = req0_valid | req1_valid;
    // Tie goes to whoever did not win last; a lone requester always wins.
    winner  = (req0_valid & req1_valid) ? ~lw_q : req1_valid;
    // Arbitrate when idle or on the final shift cycle so back-to-back words
    // leave only the LOAD cycle as a gap in the serial stream.
    arb     = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == 2'd3));

    case (state_q)
      IDLE:    ;
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = 2'd0;
      end
      SHIFT:   cnt_d = cnt_q + 2'd1;
      default: state_d = IDLE;
    endcase

    if (arb) begin
      if (any_vld) begin
        state_d = LOAD;
        g_d     = winner;
        lw_d    = winner;
      end else begin
        state_d = IDLE;
      end
    end

    // Flush overrides every transition and leaves the grant history alone.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      g_d     = g_q;
      lw_d    = lw_q;
    end

    if (state_q == LOAD) begin
      piso_load  = 1'b1;
      piso_din   = g_q ? req1_data : req0_data;
      req0_ready = ~flush & ~g_q;
      req1_ready = ~flush &  g_q;
    end

    // Tags are delayed one cycle to line up with the PISO's registered dout.
    ser_valid_d = (state_q == SHIFT) & ~flush;
    ser_last_d  = (state_q == SHIFT) & (cnt_q == 2'd3) & ~flush;
    ser_src_d   = g_q;
    piso_rst_d  = flush;
  end

  assign ser_bit   = piso_dout;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign ser_src   = ser_src_q;
  assign piso_rst  = piso_rst_q;
  assign busy      = (state_q != IDLE);
  assign err       = 1'b0;

endmodule

// File: tb/tb_shiftreg_sched.sv
module tb_shiftreg_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_data = 4'd0, req1_data = 4'd0;
  logic       req0_ready, req1_ready;
  logic       flush = 1'b0;
  logic       piso_load;
  logic [3:0] piso_din;
  logic       piso_rst;
  logic       piso_dout;
  logic       ser_bit, ser_valid, ser_src, ser_last, busy, err;

  shiftreg_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .flush(flush), .piso_load(piso_load), .piso_din(piso_din),
    .piso_rst(piso_rst), .piso_dout(piso_dout),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_src(ser_src),
    .ser_last(ser_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Shared PISO: parallel load, MSB-first shift, registered serial output.
  logic [3:0] sr;
  logic       pdout;
  always @(posedge clk) begin
    if (piso_rst) begin
      sr    <= 4'd0;
      pdout <= 1'b0;
    end else if (piso_load) begin
      sr    <= piso_din;
    end else begin
      pdout <= sr[3];
      sr    <= {sr[2:0], 1'b0};
    end
  end
  assign piso_dout = pdout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: each accepted word is an event with a load cycle L.
  // ready/load at L, busy over L..L+4, serial bits data[3..0] over L+2..L+5,
  // last at L+5; a flush at f truncates everything after f. Decisions happen
  // when the scheduler is free: every idle cycle, or L+4 of the current word.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         lc;
    logic [3:0] d;
    logic       s;
    int         cut;
  } word_t;

  word_t words[$];
  int    next_dec = 1;
  int    pend_cyc = -1;
  bit    have_pend = 0;
  logic  pend_src = 1'b0;
  logic  lw_m = 1'b1;
  bit    prev_rst_low = 1;
  bit    prev_flush = 0;

  initial begin : compare
    logic e_sv, e_last, e_busy, e_load, e_r0, e_r1, e_bit, e_src, e_prst;
    logic [3:0] e_din;
    word_t w;
    int L, idx;
    forever begin
      @(negedge clk);
      e_sv = 0; e_last = 0; e_busy = 0; e_load = 0; e_r0 = 0; e_r1 = 0;
      e_bit = 0; e_src = 0; e_prst = 0; e_din = 4'd0;
      if (!rst) begin
        words.delete();
        have_pend = 0;
        lw_m = 1'b1;
        next_dec = cyc + 1;
        e_prst = 1;
      end else begin
        if (have_pend && pend_cyc == cyc) begin
          w.lc = cyc; w.s = pend_src; w.d = pend_src ? req1_data : req0_data;
          w.cut = 32'h7fffffff;
          words.push_back(w);
          if (words.size() > 3) void'(words.pop_front());
          have_pend = 0;
        end
        if (cyc == next_dec) begin
          if (!flush && (req0_valid || req1_valid)) begin
            pend_src  = (req0_valid && req1_valid) ? ~lw_m : req1_valid;
            lw_m      = pend_src;
            have_pend = 1;
            pend_cyc  = cyc + 1;
            next_dec  = cyc + 5;
          end else begin
            next_dec = cyc + 1;
          end
        end
        if (flush) begin
          foreach (words[i]) if (words[i].cut > cyc) words[i].cut = cyc;
          have_pend = 0;
          next_dec  = cyc + 1;
        end
        e_prst = prev_rst_low || prev_flush;
        foreach (words[i]) begin
          L = words[i].lc;
          if (cyc == L) begin
            e_load = 1;
            e_din  = words[i].d;
            if (!flush) begin
              if (words[i].s) e_r1 = 1; else e_r0 = 1;
            end
          end
          if (cyc >= L && cyc <= L + 4 && cyc <= words[i].cut) e_busy = 1;
          if (cyc >= L + 2 && cyc <= L + 5 && cyc <= words[i].cut) begin
            e_sv   = 1;
            idx    = 3 - (cyc - L - 2);
            e_bit  = words[i].d[idx];
            e_src  = words[i].s;
            e_last = (cyc == L + 5);
          end
        end
      end
      prev_rst_low = !rst;
      prev_flush   = rst && flush;

      chk("ready0", req0_ready, e_r0);
      chk("ready1", req1_ready, e_r1);
      chk("piso_load", piso_load, e_load);
      chk("piso_din", piso_din, e_din);
      chk("piso_rst", piso_rst, e_prst);
      chk("busy", busy, e_busy);
      chk("ser_valid", ser_valid, e_sv);
      chk("ser_last", ser_last, e_last);
      chk("err", err, 0);
      chk("both_ready", req0_ready & req1_ready, 0);
      if (e_sv) begin
        chk("ser_bit", ser_bit, e_bit);
        chk("ser_src", ser_src, e_src);
      end
      if (!rst) chk("ser_src_rst", ser_src, 0);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic r0, output logic r1, output int at, output bit ok);
    ok = 0; r0 = 0; r1 = 0; at = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1; r0 = req0_ready; r1 = req1_ready; at = cyc;
      end
    end
  endtask

  task automatic collect(output logic [3:0] wd, output logic s, output logic lst,
                         output int st, output bit ok);
    ok = 0; wd = 4'd0; s = 0; lst = 0; st = -1;
    for (int i = 0; i < 15 && !ok; i++) begin
      @(negedge clk);
      if (ser_valid) ok = 1;
    end
    if (ok) begin
      st = cyc; wd[3] = ser_bit; s = ser_src;
      for (int j = 2; j >= 0; j--) begin
        @(negedge clk);
        wd[j] = ser_bit;
        if (!ser_valid || ser_src !== s) ok = 0;
        if (j == 0) lst = ser_last;
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !ser_valid) ok = 1;
    end
    chk({nm, "_idle_timeout"}, ok, 1);
    tick();
  endtask

  initial begin : stim
    logic r0, r1, lst, s;
    logic [3:0] wd;
    int at, st, prev_st;
    bit ok;
    logic [3:0] exp_d [4];
    logic       exp_s [4];

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_piso_rst", piso_rst, 1);
    chk("rst_ser_valid", ser_valid, 0);

    // Single word from requester 0
    tick();
    rst = 1'b1; req0_valid = 1'b1; req0_data = 4'b1011;
    wait_ready(r0, r1, at, ok);
    chk("t1_ready_timeout", ok, 1);
    chk("t1_ready0", r0, 1);
    tick();
    req0_valid = 1'b0;
    collect(wd, s, lst, st, ok);
    chk("t1_word_ok", ok, 1);
    chk("t1_word", wd, 4'b1011);
    chk("t1_src", s, 0);
    chk("t1_last", lst, 1);
    chk("t1_latency", st - at, 2);
    wait_idle("t1");
    @(negedge clk);
    chk("t1_busy_end", busy, 0);

    // Both requesters held from reset: strict alternation, 5-cycle period
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 4'hA;
    req1_valid = 1'b1; req1_data = 4'h5;
    tick(); tick();
    rst = 1'b1;
    exp_d[0] = 4'hA; exp_d[1] = 4'h5; exp_d[2] = 4'hA; exp_d[3] = 4'h5;
    exp_s[0] = 1'b0; exp_s[1] = 1'b1; exp_s[2] = 1'b0; exp_s[3] = 1'b1;
    prev_st = -1;
    for (int k = 0; k < 4; k++) begin
      collect(wd, s, lst, st, ok);
      chk("t2_word_ok", ok, 1);
      chk("t2_word", wd, exp_d[k]);
      chk("t2_src", s, exp_s[k]);
      chk("t2_last", lst, 1);
      if (k > 0) chk("t2_period", st - prev_st, 5);
      prev_st = st;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("t2");

    // Requester 1 alone, continuous
    req1_valid = 1'b1; req1_data = 4'hC;
    prev_st = -1;
    for (int k = 0; k < 3; k++) begin
      collect(wd, s, lst, st, ok);
      chk("t3_word_ok", ok, 1);
      chk("t3_word", wd, 4'hC);
      chk("t3_src", s, 1);
      if (k > 0) chk("t3_period", st - prev_st, 5);
      prev_st = st;
    end
    tick();
    req1_valid = 1'b0;
    wait_idle("t3");

    // Flush during the second shift cycle
    req0_valid = 1'b1; req0_data = 4'h6;
    wait_ready(r0, r1, at, ok);
    chk("t4_ready_timeout", ok, 1);
    chk("t4_ready0", r0, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_piso_rst_pulse", piso_rst, 1);
    chk("t4_busy_after", busy, 0);
    chk("t4_ser_valid_after", ser_valid, 0);
    @(negedge clk);
    chk("t4_piso_rst_drop", piso_rst, 0);
    tick();
    req1_valid = 1'b1; req1_data = 4'h9;
    collect(wd, s, lst, st, ok);
    chk("t4_word_ok", ok, 1);
    chk("t4_word", wd, 4'h9);
    chk("t4_src", s, 1);
    tick();
    req1_valid = 1'b0;
    wait_idle("t4");

    // Asynchronous reset in the middle of a shift
    req0_valid = 1'b1; req0_data = 4'h3;
    req1_valid = 1'b1; req1_data = 4'hC;
    wait_ready(r0, r1, at, ok);
    chk("t5_ready_timeout", ok, 1);
    tick(); tick();
    chk("t5_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ser_valid", ser_valid, 0);
    chk("t5_async_ser_last", ser_last, 0);
    chk("t5_async_piso_rst", piso_rst, 1);
    chk("t5_async_load", piso_load, 0);
    chk("t5_async_ready", {req0_ready, req1_ready}, 2'b00);
    tick(); tick();
    rst = 1'b1;
    wait_ready(r0, r1, at, ok);
    chk("t5_post_ready_timeout", ok, 1);
    chk("t5_tie_req0", {r0, r1}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("t5");

    // Flush while idle still pulses piso_rst and keeps the grant history
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t6_idle_flush_prst", piso_rst, 1);
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_ready(r0, r1, at, ok);
    chk("t6_ready_timeout", ok, 1);
    chk("t6_tie_req1", {r0, r1}, 2'b01);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shiftreg_sched.md
SHIFTREG_SCHED -- requirements
Module: shiftreg_sched

Interface
REQ-001 Module SHALL carry the tamara_triplicate attribute; port err SHALL carry tamara_error_sink.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n has a 4-bit word pending.
REQ-005 req0_data / req1_data  input  4  requester n word; held stable while valid and not ready.
REQ-006 req0_ready / req1_ready  output  1  word accepted this cycle.
REQ-007 flush  input  1  synchronous abort of in-flight word.
REQ-008 piso_load  output  1  drives the shared PISO's load.
REQ-009 piso_din  output  4  drives the shared PISO's din.
REQ-010 piso_rst  output  1  drives the shared PISO's synchronous active-high rst.
REQ-011 piso_dout  input  1  PISO serial output.
REQ-012 ser_bit  output  1  combinational pass-through of piso_dout.
REQ-013 ser_valid  output  1  ser_bit is a live data bit.
REQ-014 ser_src  output  1  requester index owning ser_bit.
REQ-015 ser_last  output  1  ser_bit is bit 0 of its word.
REQ-016 busy  output  1  FSM not in IDLE.
REQ-017 err  output  1  error sink; RTL drives constant 0; TMR pass supplies voter mismatch.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT; 2-bit shift counter cnt; registered grant g; registered last-winner lw.
REQ-019 Arbitration SHALL occur in IDLE, and in SHIFT when cnt==3: if any valid, next state LOAD, g = winner; otherwise IDLE from SHIFT, stay IDLE.
REQ-020 Winner SHALL be round-robin: both valid -> requester != lw; one valid -> that one; lw updates to g on entering LOAD.
REQ-021 In LOAD: piso_load=1, piso_din=req[g]_data, req[g]_ready=1 for exactly that cycle; next state SHIFT, cnt=0.
REQ-022 Outside LOAD: piso_load=0, piso_din=0, both ready=0.
REQ-023 SHIFT SHALL last exactly 4 cycles (cnt 0..3).
REQ-024 ser_valid SHALL be a one-cycle-delayed copy of (state==SHIFT); ser_src and ser_last (delayed cnt==3) delayed identically, so ser_bit shows data[3],[2],[1],[0] in the 4 cycles after the SHIFT cycles begin +1.
REQ-025 Latency: LOAD in cycle t -> ser_valid with data[3] in cycle t+2, ser_last in cycle t+5.
REQ-026 Back-to-back words SHALL stream with 5-cycle period; ser_valid gaps of exactly 1 cycle (LOAD of next word).
REQ-027 flush SHALL have priority over all transitions: next state IDLE, no ready asserted in the flush cycle, piso_rst=1 for the following cycle, ser_valid/ser_last forced 0 from the following cycle.
REQ-028 flush in IDLE SHALL still pulse piso_rst once; lw unchanged by flush.
REQ-029 A requester dropping valid while not granted SHALL have no effect; valid dropped while in LOAD for g is a protocol violation (undefined word).

Reset
REQ-030 While rst low: state IDLE, cnt=0, g=0, lw=1 (requester 0 wins first tie), ser_valid=0, ser_last=0, ser_src=0, piso_load=0, piso_din=0, both ready=0, busy=0, piso_rst=1.
REQ-031 piso_rst SHALL deassert on the first clk edge after rst release; no LOAD SHALL occur before that edge.
REQ-032 Reset mid-word SHALL abandon the word with no ready re-assertion for it.

Verification (bench includes the PISO model)
REQ-033 Release reset, req0_valid=1 data=4'b1011 -> ready0 one cycle, ser_bit 1,0,1,1 with ser_valid, ser_src=0, ser_last on final bit, busy back to 0.
REQ-034 Both valid from reset, req0=4'hA req1=4'h5 held -> order req0,req1,req0,req1; ser_valid pattern 4 on/1 off.
REQ-035 req1 only, continuous, data 4'hC -> every word on ser_src=1, 5-cycle period, no starvation checks needed.
REQ-036 flush asserted during second SHIFT cycle -> piso_rst pulse next cycle, ser_valid 0 thereafter, IDLE, next req served cleanly from fresh LOAD.
REQ-037 rst asserted low mid-SHIFT -> all outputs to REQ-030 values asynchronously; after release, req0 wins a tie.
REQ-038 All cases: err remains 0; ready never asserted to both requesters in one cycle.
